// File: rtl/fetch_stage_pkg.sv
// Shared constants and helpers for the MIPS fetch stage: reset/handler PCs,
// instruction-memory window, exception codes and the fetch address check.
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] IM_BASE    = 32'h0000_3000;
  localparam int unsigned IM_WORDS   = 4096;
  localparam logic [31:0] IM_LIMIT   = IM_BASE + 32'(IM_WORDS * 4);

  localparam logic [4:0]  EXC_NONE   = 5'd0;
  localparam logic [4:0]  EXC_ADEL   = 5'd4;
  localparam logic [31:0] NOP        = 32'h0;

  // AdEL on a misaligned PC or one outside [IM_BASE, IM_LIMIT)
  function automatic logic is_adel(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc >= IM_LIMIT);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// F/D pipeline register: reset, then interrupt flush, then eret flush,
// then stall hold, otherwise capture the fetched instruction.
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush_int,
  input  logic        flush_eret,
  input  logic        stall,
  input  logic [31:0] epc,
  input  logic [31:0] pc_in,
  input  logic [31:0] inst_in,
  input  logic        bd_in,
  input  logic [4:0]  exc_in,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out,
  output logic        bd_out,
  output logic [4:0]  exc_out
);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_out   <= 32'h0;
      inst_out <= NOP;
      bd_out   <= 1'b0;
      exc_out  <= EXC_NONE;
    end else if (flush_int) begin
      pc_out   <= HANDLER_PC;
      inst_out <= NOP;
      bd_out   <= 1'b0;
      exc_out  <= EXC_NONE;
    end else if (flush_eret) begin
      // bubble is tagged with the eret target so decode sees a sane PC
      pc_out   <= epc;
      inst_out <= NOP;
      bd_out   <= 1'b0;
      exc_out  <= EXC_NONE;
    end else if (!stall) begin
      pc_out   <= pc_in;
      inst_out <= inst_in;
      bd_out   <= bd_in;
      exc_out  <= exc_in;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, AdEL detection and F/D register instance.
// Optional FETCH_PERF_EN macro adds saturating fetch/stall counters.
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] NPC,
  input  logic        STALL,
  input  logic        INTREQ,
  input  logic        EXLCLR,
  input  logic        BRD,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] i_inst_addr,
  output logic [31:0] PCF,
  output logic [31:0] PCA4F,
  output logic [31:0] PCD,
  output logic [31:0] INSTRD,
  output logic        BDD,
  output logic [4:0]  EXCCODED
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_stall
`endif
);

  logic [31:0] pc_q;
  logic        flush;
  logic        adel;
  logic [31:0] fetch_word;
  logic [4:0]  fetch_exc;

  assign flush = INTREQ || EXLCLR;

  // a flush must redirect fetch even while decode is stalled
  always_ff @(posedge clk) begin
    if (reset)
      pc_q <= RESET_PC;
    else if (flush || !STALL)
      pc_q <= NPC;
  end

  assign PCF         = pc_q;
  assign i_inst_addr = pc_q;
  assign PCA4F       = pc_q + 32'd4;

  assign adel       = is_adel(pc_q);
  assign fetch_word = adel ? NOP : i_inst_rdata;
  assign fetch_exc  = adel ? EXC_ADEL : EXC_NONE;

  if_id_reg u_if_id_reg (
    .clk       (clk),
    .reset     (reset),
    .flush_int (INTREQ),
    .flush_eret(EXLCLR),
    .stall     (STALL),
    .epc       (NPC),
    .pc_in     (pc_q),
    .inst_in   (fetch_word),
    .bd_in     (BRD),
    .exc_in    (fetch_exc),
    .pc_out    (PCD),
    .inst_out  (INSTRD),
    .bd_out    (BDD),
    .exc_out   (EXCCODED)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch <= 32'h0;
      perf_stall <= 32'h0;
    end else begin
      if (!STALL && !flush && perf_fetch != 32'hFFFF_FFFF)
        perf_fetch <= perf_fetch + 32'd1;
      if (STALL && !flush && perf_stall != 32'hFFFF_FFFF)
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage; instruction memory returns
// {16'hABCD, addr[15:0]} so captured words identify their fetch address.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] NPC;
  logic        STALL, INTREQ, EXLCLR, BRD;
  logic [31:0] i_inst_rdata;
  logic [31:0] i_inst_addr, PCF, PCA4F, PCD, INSTRD;
  logic        BDD;
  logic [4:0]  EXCCODED;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch, perf_stall;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign i_inst_rdata = {16'hABCD, i_inst_addr[15:0]};

  fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .NPC         (NPC),
    .STALL       (STALL),
    .INTREQ      (INTREQ),
    .EXLCLR      (EXLCLR),
    .BRD         (BRD),
    .i_inst_rdata(i_inst_rdata),
    .i_inst_addr (i_inst_addr),
    .PCF         (PCF),
    .PCA4F       (PCA4F),
    .PCD         (PCD),
    .INSTRD      (INSTRD),
    .BDD         (BDD),
    .EXCCODED    (EXCCODED)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch  (perf_fetch),
    .perf_stall  (perf_stall)
`endif
  );

  typedef struct {
    logic        rst;
    logic [31:0] npc;
    logic        stall;
    logic        intreq;
    logic        exlclr;
    logic        brd;
    logic [31:0] e_pcf;
    logic [31:0] e_pca4f;
    logic [31:0] e_pcd;
    logic [31:0] e_instrd;
    logic        e_bdd;
    logic [4:0]  e_exc;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic rst, input logic [31:0] npc, input logic stall,
                         input logic intreq, input logic exlclr, input logic brd,
                         input logic [31:0] e_pcf, input logic [31:0] e_pca4f,
                         input logic [31:0] e_pcd, input logic [31:0] e_instrd,
                         input logic e_bdd, input logic [4:0] e_exc);
    vec_t v;
    v.rst = rst; v.npc = npc; v.stall = stall; v.intreq = intreq;
    v.exlclr = exlclr; v.brd = brd; v.e_pcf = e_pcf; v.e_pca4f = e_pca4f;
    v.e_pcd = e_pcd; v.e_instrd = e_instrd; v.e_bdd = e_bdd; v.e_exc = e_exc;
    vecs.push_back(v);
  endtask

  // drive at the falling edge, let the rising edge capture, sample 1 ns later
  task automatic applyStimulus(input logic rst, input logic [31:0] npc, input logic stall,
                               input logic intreq, input logic exlclr, input logic brd);
    @(negedge clk);
    reset = rst; NPC = npc; STALL = stall; INTREQ = intreq; EXLCLR = exlclr; BRD = brd;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int idx,
                             input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s step %0d: got %h expected %h", name, idx, actual, expected);
    end
  endtask

  initial begin
    reset = 1'b1; NPC = 32'h0; STALL = 1'b0; INTREQ = 1'b0; EXLCLR = 1'b0; BRD = 1'b0;

    //      rst npc            st in ex br  PCF            PCA4F          PCD            INSTRD         BDD exc
    add_vec(1, 32'h0000_0000, 0, 0, 0, 0, 32'h0000_3000, 32'h0000_3004, 32'h0000_0000, 32'h0000_0000, 0, 5'd0);
    add_vec(0, 32'h0000_3004, 0, 0, 0, 0, 32'h0000_3004, 32'h0000_3008, 32'h0000_3000, 32'hABCD_3000, 0, 5'd0);
    add_vec(0, 32'h0000_3008, 0, 0, 0, 0, 32'h0000_3008, 32'h0000_300C, 32'h0000_3004, 32'hABCD_3004, 0, 5'd0);
    add_vec(0, 32'h0000_300C, 0, 0, 0, 0, 32'h0000_300C, 32'h0000_3010, 32'h0000_3008, 32'hABCD_3008, 0, 5'd0);
    add_vec(0, 32'h0000_3010, 0, 0, 0, 0, 32'h0000_3010, 32'h0000_3014, 32'h0000_300C, 32'hABCD_300C, 0, 5'd0);
    add_vec(0, 32'h0000_3014, 1, 0, 0, 0, 32'h0000_3010, 32'h0000_3014, 32'h0000_300C, 32'hABCD_300C, 0, 5'd0);
    add_vec(0, 32'h0000_3014, 1, 0, 0, 0, 32'h0000_3010, 32'h0000_3014, 32'h0000_300C, 32'hABCD_300C, 0, 5'd0);
    add_vec(0, 32'h0000_3014, 0, 0, 0, 0, 32'h0000_3014, 32'h0000_3018, 32'h0000_3010, 32'hABCD_3010, 0, 5'd0);
    add_vec(0, 32'h0000_4180, 1, 1, 0, 0, 32'h0000_4180, 32'h0000_4184, 32'h0000_4180, 32'h0000_0000, 0, 5'd0);
    add_vec(0, 32'h0000_4184, 0, 0, 0, 0, 32'h0000_4184, 32'h0000_4188, 32'h0000_4180, 32'hABCD_4180, 0, 5'd0);
    add_vec(0, 32'h0000_3002, 0, 0, 0, 0, 32'h0000_3002, 32'h0000_3006, 32'h0000_4184, 32'hABCD_4184, 0, 5'd0);
    add_vec(0, 32'h0000_2FFC, 0, 0, 0, 0, 32'h0000_2FFC, 32'h0000_3000, 32'h0000_3002, 32'h0000_0000, 0, 5'd4);
    add_vec(0, 32'h0000_3020, 0, 0, 0, 0, 32'h0000_3020, 32'h0000_3024, 32'h0000_2FFC, 32'h0000_0000, 0, 5'd4);
    add_vec(0, 32'h0000_3024, 0, 0, 0, 1, 32'h0000_3024, 32'h0000_3028, 32'h0000_3020, 32'hABCD_3020, 1, 5'd0);
    add_vec(0, 32'h0000_3100, 0, 0, 1, 0, 32'h0000_3100, 32'h0000_3104, 32'h0000_3100, 32'h0000_0000, 0, 5'd0);
    add_vec(0, 32'h0000_3104, 0, 0, 0, 0, 32'h0000_3104, 32'h0000_3108, 32'h0000_3100, 32'hABCD_3100, 0, 5'd0);
    add_vec(0, 32'h0000_4200, 0, 1, 1, 0, 32'h0000_4200, 32'h0000_4204, 32'h0000_4180, 32'h0000_0000, 0, 5'd0);
    add_vec(0, 32'h0000_7000, 0, 0, 0, 0, 32'h0000_7000, 32'h0000_7004, 32'h0000_4200, 32'hABCD_4200, 0, 5'd0);
    add_vec(0, 32'h0000_6FFC, 0, 0, 0, 0, 32'h0000_6FFC, 32'h0000_7000, 32'h0000_7000, 32'h0000_0000, 0, 5'd4);
    add_vec(0, 32'hFFFF_FFFC, 0, 0, 0, 0, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_6FFC, 32'hABCD_6FFC, 0, 5'd0);
    add_vec(1, 32'h0000_5000, 1, 1, 1, 1, 32'h0000_3000, 32'h0000_3004, 32'h0000_0000, 32'h0000_0000, 0, 5'd0);
    add_vec(0, 32'h0000_3004, 0, 0, 0, 1, 32'h0000_3004, 32'h0000_3008, 32'h0000_3000, 32'hABCD_3000, 1, 5'd0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].npc, vecs[i].stall, vecs[i].intreq,
                    vecs[i].exlclr, vecs[i].brd);
      checkOutput("PCF",      i, PCF,               vecs[i].e_pcf);
      checkOutput("ADDR",     i, i_inst_addr,       vecs[i].e_pcf);
      checkOutput("PCA4F",    i, PCA4F,             vecs[i].e_pca4f);
      checkOutput("PCD",      i, PCD,               vecs[i].e_pcd);
      checkOutput("INSTRD",   i, INSTRD,            vecs[i].e_instrd);
      checkOutput("BDD",      i, {31'h0, BDD},      {31'h0, vecs[i].e_bdd});
      checkOutput("EXCCODED", i, {27'h0, EXCCODED}, {27'h0, vecs[i].e_exc});
    end

    // eret must override a stall: PC redirects and decode gets the EPC bubble
    applyStimulus(0, 32'h0000_3200, 1, 0, 1, 0);
    checkOutput("ERET_STALL_PCF", 100, PCF, 32'h0000_3200);
    checkOutput("ERET_STALL_PCD", 100, PCD, 32'h0000_3200);
    checkOutput("ERET_STALL_INS", 100, INSTRD, 32'h0000_0000);
    applyStimulus(0, 32'h0000_3204, 0, 0, 0, 0);
    checkOutput("ERET_NEXT_INS", 101, INSTRD, 32'hABCD_3200);

`ifdef FETCH_PERF_EN
    applyStimulus(1, 32'h0000_0000, 0, 0, 0, 0);
    checkOutput("PERF_FETCH_RST", 200, perf_fetch, 32'd0);
    checkOutput("PERF_STALL_RST", 200, perf_stall, 32'd0);
    for (int k = 0; k < 10; k++)
      applyStimulus(0, 32'h0000_3000 + 32'(4 * (k + 1)), 0, 0, 0, 0);
    for (int k = 0; k < 3; k++)
      applyStimulus(0, 32'h0000_3028, 1, 0, 0, 0);
    applyStimulus(0, 32'h0000_4180, 0, 1, 0, 0);
    checkOutput("PERF_FETCH", 201, perf_fetch, 32'd10);
    checkOutput("PERF_STALL", 201, perf_stall, 32'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Pipeline fetch stage of the five-stage MIPS core: holds the fetch PC register, drives the instruction-memory address, detects fetch address errors and registers the fetched instruction into the F/D pipeline register. Consumes the next-PC value produced by the next-PC logic and feeds the current fetch PC back to it, along with `PCF + 4`. Applies stall, interrupt and `eret` flush so that decode always sees a well-defined instruction, PC, delay-slot flag and exception code.

## Interface
- `RESET_PC`, `32'h0000_3000`, PC value after reset.
- `HANDLER_PC`, `32'h0000_4180`, PC tagged on the bubble inserted by an interrupt/exception flush.
- `IM_BASE`, `32'h0000_3000`, lowest legal instruction address.
- `IM_WORDS`, `4096`, instruction memory depth in 32-bit words.
- `clk  input  1`: clock; all state updates on the rising edge.
- `reset  input  1`: synchronous, active-high reset.
- `NPC  input  32`: next fetch address from the next-PC logic.
- `STALL  input  1`: hazard stall; freezes the PC and the F/D register.
- `INTREQ  input  1`: interrupt/exception taken this cycle; forces update and flush.
- `EXLCLR  input  1`: `eret` in decode; forces update and flush.
- `BRD  input  1`: the instruction currently in decode is a branch or jump.
- `i_inst_rdata  input  32`: instruction word, combinational read of `i_inst_addr`.
- `i_inst_addr  output  32`: equals `PCF`.
- `PCF  output  32`: current fetch PC, returned to the next-PC logic.
- `PCA4F  output  32`: `PCF + 4`.
- `PCD  output  32`: PC of the instruction in decode.
- `INSTRD  output  32`: instruction in decode.
- `BDD  output  1`: the decode instruction is in a branch delay slot.
- `EXCCODED  output  5`: exception code carried into decode (0 = none).

## Operation
- PC register update, highest priority first:
  - `reset`: `RESET_PC`.
  - `INTREQ` or `EXLCLR`: `NPC`. This overrides `STALL`.
  - `STALL`: hold.
  - Otherwise: `NPC`.
- Fetch address error (AdEL) when either condition holds:
  - `PCF[1:0] != 0`
  - `PCF < IM_BASE` or `PCF >= IM_BASE + 4*IM_WORDS`
- On AdEL, the fetched word is replaced by `32'h0` (nop) and the exception code is `5'd4`. Otherwise the word is `i_inst_rdata` and the code is 0.
- F/D register update, highest priority first:
  - `reset`: `PCD=0`, `INSTRD=0`, `BDD=0`, `EXCCODED=0`.
  - `INTREQ`: bubble. `INSTRD=0`, `EXCCODED=0`, `BDD=0`, `PCD=HANDLER_PC`.
  - `EXLCLR`: bubble. `INSTRD=0`, `EXCCODED=0`, `BDD=0`, `PCD=NPC` (the EPC target).
  - `STALL`: hold all fields.
  - Otherwise: `PCD=PCF`, `INSTRD`=fetched word, `BDD=BRD`, `EXCCODED`=fetch code.
- `INTREQ` and `EXLCLR` in the same cycle: `INTREQ` wins.
- Address arithmetic is 32-bit modulo 2^32. `PCA4F` wraps at `32'hFFFF_FFFC`.

## Timing
- Fetch is single-cycle: `i_inst_addr` is valid from the clock edge and the instruction is captured at the next edge.
- `NPC` sampled at edge *n* is presented on `PCF` during cycle *n+1*.
- A stall asserted in cycle *n* holds the PC and the F/D register across edge *n*.
- A flush in cycle *n* produces the bubble in decode during cycle *n+1*. The handler/EPC instruction reaches decode in cycle *n+2*.
- Reset applied mid-operation takes effect at the next edge regardless of `STALL`, `INTREQ` or `EXLCLR`.
- All outputs are registered except `PCA4F` and `i_inst_addr`.

## Configuration
- `FETCH_PERF_EN` defined:
  - Adds two 32-bit saturating counters:
    - `perf_fetch`: advancing (non-stall, non-flush) fetches.
    - `perf_stall`: stall cycles.
  - Adds output ports `perf_fetch` and `perf_stall`.
  - Both counters clear on `reset`.
- Undefined: the counters and their ports are absent. Stage behaviour is otherwise identical.

## Structure
- Shared package holds:
  - `RESET_PC`, `HANDLER_PC`
  - `EXC_ADEL = 5'd4`, `EXC_NONE = 5'd0`
  - `NOP = 32'h0`
- One sub-module, `if_id_reg`, holds the F/D register with reset/flush/stall priority. The PC register and the AdEL check stay in `fetch_stage`.

## Test plan
- Reset then free-run with `NPC=PCA4F` → `PCF` = 0x3000, 0x3004, 0x3008. `PCD` lags `PCF` by one cycle. `EXCCODED=0`.
- `STALL` high for 2 cycles at `PCF=0x3010` → `PCF`, `PCD` and `INSTRD` hold for 2 cycles, then resume at 0x3014.
- `INTREQ` during a stall with `NPC=0x4180` → next cycle `PCF=0x4180`, decode holds a bubble with `PCD=0x4180`. The cycle after, decode holds the handler's first instruction.
- `NPC=0x3002`, then `NPC=0x2FFC` → each yields `INSTRD=0`, `EXCCODED=4` in decode, with `PCD` equal to the faulting address.
- `BRD=1` on a normal advance → `BDD=1` for the delay-slot instruction. An `EXLCLR` flush with `NPC=0x3100` → bubble with `PCD=0x3100`, `BDD=0`.
- With `FETCH_PERF_EN`: 10 advancing cycles, 3 stall cycles and 1 flush → `perf_fetch=10`, `perf_stall=3`.
